bcp_scan_engine: RTL and testbench

- Parametrised Boolean-constraint-propagation engine for the SAT datapath; successor to the fixed-size BCP unit.
- Holds a clause bank as positive/negative literal masks and scans LANES clauses per cycle. Applies unit implications to an internal assignment and repeats passes until fixpoint or conflict.
- Sits between the decision/VST logic (supplies the start assignment, consumes implications) and conflict analysis (consumes the conflict clause index).

---
 rtl/bcp_scan_if.sv | 33 +++
 rtl/bcp_scan_engine.sv | 123 ++++++++++++
 tb/tb_bcp_scan_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcp_scan_if.sv
// bcp_scan_if: clause-load, start and propagation-result signals of the BCP scan engine
interface bcp_scan_if #(
  parameter int VAR_NUM    = 16,
  parameter int CLAUSE_NUM = 32
);
  localparam int IW = $clog2(CLAUSE_NUM);
  localparam int VW = $clog2(VAR_NUM);
  logic               load_en;
  logic [IW-1:0]      load_idx;
  logic [VAR_NUM-1:0] load_pos;
  logic [VAR_NUM-1:0] load_neg;
  logic               start;
  logic [VAR_NUM-1:0] init_assigned;
  logic [VAR_NUM-1:0] init_value;
  logic               busy;
  logic               done;
  logic               conflict;
  logic [IW-1:0]      conflict_idx;
  logic               imp_valid;
  logic [VW-1:0]      imp_var;
  logic               imp_val;
  logic [VW:0]        imp_count;
  logic [VAR_NUM-1:0] assigned;
  logic [VAR_NUM-1:0] value;
  modport master (
    output load_en, load_idx, load_pos, load_neg, start, init_assigned, init_value,
    input  busy, done, conflict, conflict_idx, imp_valid, imp_var, imp_val, imp_count, assigned, value
  );
  modport slave (
    input  load_en, load_idx, load_pos, load_neg, start, init_assigned, init_value,
    output busy, done, conflict, conflict_idx, imp_valid, imp_var, imp_val, imp_count, assigned, value
  );
endinterface

// File: rtl/bcp_scan_engine.sv
// bcp_scan_engine: scans LANES clauses per cycle, applying unit implications until fixpoint or conflict
module bcp_scan_engine #(
  parameter int VAR_NUM    = 16,
  parameter int CLAUSE_NUM = 32,
  parameter int LANES      = 4
) (
  input logic       clk,
  input logic       rst,
  bcp_scan_if.slave bus
);
  localparam int IW = $clog2(CLAUSE_NUM);
  localparam int VW = $clog2(VAR_NUM);
  localparam int GN = CLAUSE_NUM / LANES;
  localparam int GW = GN > 1 ? $clog2(GN) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [VAR_NUM-1:0] pos_bank [CLAUSE_NUM];
  logic [VAR_NUM-1:0] neg_bank [CLAUSE_NUM];
  logic [GW-1:0] grp_ptr;
  logic changed;
  logic [VAR_NUM-1:0] lp [LANES];
  logic [VAR_NUM-1:0] ln [LANES];
  logic [VAR_NUM-1:0] lfree [LANES];
  logic lsat [LANES];
  logic any_fals, any_unit, unit_val;
  logic [IW-1:0] fals_idx;
  logic [VW-1:0] unit_var;
  // Lanes walk high to low so the lowest-index hit wins.
  always_comb begin
    any_fals = 1'b0;
    any_unit = 1'b0;
    fals_idx = '0;
    unit_var = '0;
    unit_val = 1'b0;
    for (int l = LANES - 1; l >= 0; l--) begin
      lp[l] = pos_bank[IW'(int'(grp_ptr) * LANES + l)];
      ln[l] = neg_bank[IW'(int'(grp_ptr) * LANES + l)];
      lsat[l] = |(((lp[l] & bus.value) | (ln[l] & ~bus.value)) & bus.assigned);
      lfree[l] = (lp[l] | ln[l]) & ~bus.assigned;
      if (!lsat[l] && lfree[l] == '0) begin
        any_fals = 1'b1;
        fals_idx = IW'(int'(grp_ptr) * LANES + l);
      end
      if (!lsat[l] && lfree[l] != '0 && (lfree[l] & (lfree[l] - 1'b1)) == '0) begin
        any_unit = 1'b1;
        unit_val = |(lp[l] & lfree[l]);
        for (int b = 0; b < VAR_NUM; b++) if (lfree[l][b]) unit_var = VW'(b);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp_ptr <= '0;
      changed <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.conflict <= 1'b0;
      bus.conflict_idx <= '0;
      bus.imp_valid <= 1'b0;
      bus.imp_var <= '0;
      bus.imp_val <= 1'b0;
      bus.imp_count <= '0;
      bus.assigned <= '0;
      bus.value <= '0;
      for (int i = 0; i < CLAUSE_NUM; i++) begin
        pos_bank[i] <= '0;
        neg_bank[i] <= '0;
      end
    end else begin
      bus.done <= 1'b0;
      bus.imp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) begin
            pos_bank[bus.load_idx] <= bus.load_pos;
            neg_bank[bus.load_idx] <= bus.load_neg;
          end
          if (bus.start) begin
            bus.assigned <= bus.init_assigned;
            bus.value <= bus.init_value & bus.init_assigned;
            bus.imp_count <= '0;
            bus.conflict <= 1'b0;
            bus.busy <= 1'b1;
            changed <= 1'b0;
            grp_ptr <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (any_fals) begin
            bus.conflict <= 1'b1;
            bus.conflict_idx <= fals_idx;
            bus.busy <= 1'b0;
            state <= DONE;
          end else begin
            if (any_unit) begin
              bus.assigned[unit_var] <= 1'b1;
              bus.value[unit_var] <= unit_val;
              bus.imp_valid <= 1'b1;
              bus.imp_var <= unit_var;
              bus.imp_val <= unit_val;
              bus.imp_count <= bus.imp_count + 1'b1;
            end
            if (grp_ptr == GW'(GN - 1)) begin
              grp_ptr <= '0;
              changed <= 1'b0;
              bus.busy <= changed | any_unit;
              state <= (changed | any_unit) ? SCAN : DONE;
            end else begin
              grp_ptr <= grp_ptr + 1'b1;
              changed <= changed | any_unit;
            end
          end
        end
        default: begin
          bus.done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcp_scan_engine.sv
// tb_bcp_scan_engine: directed and random propagation runs checked against a pass-by-pass reference model
module tb_bcp_scan_engine;
  localparam int V = 16, C = 32, L = 4, G = C / L;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcp_scan_if #(.VAR_NUM(V), .CLAUSE_NUM(C)) bus ();
  bcp_scan_engine #(.VAR_NUM(V), .CLAUSE_NUM(C), .LANES(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  logic [15:0] mpos [C];
  logic [15:0] mneg [C];
  int e_conf, e_cidx, e_cnt, e_cyc;
  logic [15:0] e_asg, e_val;
  int e_imp[$];
  int o_imp[$];
  int o_cyc, o_dones;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [15:0] ia, input logic [15:0] iv);
    logic [15:0] a, v, fr;
    bit ch, sat;
    int fi, ui, k, c;
    a = ia;
    v = iv & ia;
    e_imp.delete();
    e_conf = 0;
    e_cidx = 0;
    e_cyc = 0;
    for (int pass = 0; pass < 100; pass++) begin
      ch = 0;
      for (int g = 0; g < G; g++) begin
        e_cyc++;
        fi = -1;
        ui = -1;
        for (int l = L - 1; l >= 0; l--) begin
          c = g * L + l;
          sat = |(((mpos[c] & v) | (mneg[c] & ~v)) & a);
          fr = (mpos[c] | mneg[c]) & ~a;
          if (!sat && fr == 0) fi = c;
          if (!sat && $countones(fr) == 1) ui = c;
        end
        if (fi >= 0) begin
          e_conf = 1;
          e_cidx = fi;
          e_cyc++;
          e_asg = a;
          e_val = v;
          e_cnt = e_imp.size();
          return;
        end
        if (ui >= 0) begin
          fr = (mpos[ui] | mneg[ui]) & ~a;
          k = 0;
          for (int b = 0; b < 16; b++) if (fr[b]) k = b;
          a[k] = 1'b1;
          v[k] = mpos[ui][k];
          e_imp.push_back(k * 2 + int'(mpos[ui][k]));
          ch = 1;
        end
      end
      if (!ch) break;
    end
    e_cyc++;
    e_asg = a;
    e_val = v;
    e_cnt = e_imp.size();
  endtask
  task automatic load_all();
    for (int i = 0; i < C; i++) begin
      @(negedge clk);
      bus.load_en = 1'b1;
      bus.load_idx = 5'(i);
      bus.load_pos = mpos[i];
      bus.load_neg = mneg[i];
    end
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask
  task automatic run(input logic [15:0] ia, input logic [15:0] iv, input bit inject);
    @(negedge clk);
    bus.init_assigned = ia;
    bus.init_value = iv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    o_imp.delete();
    o_cyc = 0;
    o_dones = 0;
    while (o_dones == 0 && o_cyc < 3000) begin
      @(posedge clk);
      #1;
      o_cyc++;
      if (bus.imp_valid) o_imp.push_back(int'(bus.imp_var) * 2 + int'(bus.imp_val));
      if (bus.done) o_dones++;
      if (inject && o_cyc == 3) begin
        bus.load_en = 1'b1;
        bus.load_idx = '0;
        bus.load_pos = '0;
        bus.load_neg = '0;
        bus.init_assigned = '0;
        bus.start = 1'b1;
      end
      if (inject && o_cyc == 4) begin
        bus.load_en = 1'b0;
        bus.start = 1'b0;
      end
    end
    if (o_dones == 0) chk("timeout", 0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) o_dones++;
    end
    chk("done_once", o_dones, 1);
  endtask
  task automatic cmp(input string t);
    chk({t, "_conf"}, bus.conflict, e_conf);
    if (e_conf != 0) chk({t, "_cidx"}, bus.conflict_idx, e_cidx);
    chk({t, "_cnt"}, bus.imp_count, e_cnt);
    chk({t, "_asg"}, bus.assigned, e_asg);
    chk({t, "_val"}, bus.value, e_val);
    chk({t, "_cyc"}, o_cyc, e_cyc);
    chk({t, "_nimp"}, o_imp.size(), e_imp.size());
    for (int i = 0; i < o_imp.size() && i < e_imp.size(); i++) chk({t, "_imp"}, o_imp[i], e_imp[i]);
  endtask
  task automatic fill(input logic [15:0] p);
    for (int i = 0; i < C; i++) begin
      mpos[i] = p;
      mneg[i] = '0;
    end
  endtask
  initial begin
    bus.load_en = 1'b0;
    bus.load_idx = '0;
    bus.load_pos = '0;
    bus.load_neg = '0;
    bus.start = 1'b0;
    bus.init_assigned = '0;
    bus.init_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_conf", bus.conflict, 0);
    chk("rst_cnt", bus.imp_count, 0);
    chk("rst_asg", bus.assigned, 0);
    chk("rst_val", bus.value, 0);
    rst = 1'b0;
    fill(16'h0000);
    model(16'h0000, 16'h0000);
    run(16'h0000, 16'h0000, 0);
    chk("empty_conf", bus.conflict, 1);
    chk("empty_cidx", bus.conflict_idx, 0);
    cmp("empty");
    fill(16'h0001);
    mpos[0] = 16'h0003;
    load_all();
    model(16'h0001, 16'h0001);
    run(16'h0001, 16'h0001, 0);
    chk("fix_cyc", o_cyc, 9);
    chk("fix_conf", bus.conflict, 0);
    chk("fix_cnt", bus.imp_count, 0);
    chk("fix_asg", bus.assigned, 16'h0001);
    cmp("fix");
    fill(16'h0001);
    mpos[0] = 16'h0002;
    mneg[0] = 16'h0001;
    mpos[5] = 16'h0004;
    mneg[5] = 16'h0002;
    load_all();
    model(16'h0001, 16'h0001);
    for (int r = 0; r < 3; r++) begin
      run(16'h0001, 16'h0001, r == 1);
      chk("chain_cnt", bus.imp_count, 2);
      chk("chain_asg", bus.assigned, 16'h0007);
      chk("chain_val", bus.value, 16'h0007);
      chk("chain_conf", bus.conflict, 0);
      chk("chain_nimp", o_imp.size(), 2);
      if (o_imp.size() == 2) begin
        chk("chain_imp0", o_imp[0], 3);
        chk("chain_imp1", o_imp[1], 5);
      end
      cmp("chain");
    end
    fill(16'h0001);
    mpos[0] = 16'h0002;
    mpos[1] = 16'h0000;
    mneg[1] = 16'h0002;
    load_all();
    model(16'h0001, 16'h0001);
    run(16'h0001, 16'h0001, 0);
    chk("cfl_conf", bus.conflict, 1);
    chk("cfl_cidx", bus.conflict_idx, 1);
    chk("cfl_cnt", bus.imp_count, 1);
    cmp("cfl");
    fill(16'h0001);
    mpos[1] = 16'h0002;
    mpos[2] = 16'h0000;
    mneg[2] = 16'h0001;
    load_all();
    model(16'h0001, 16'h0001);
    run(16'h0001, 16'h0001, 0);
    chk("prio_conf", bus.conflict, 1);
    chk("prio_cidx", bus.conflict_idx, 2);
    chk("prio_nimp", o_imp.size(), 0);
    cmp("prio");
    for (int r = 0; r < 15; r++) begin
      logic [15:0] ia, iv;
      for (int i = 0; i < C; i++) begin
        mpos[i] = 16'($urandom & $urandom & $urandom) & 16'h00ff;
        mneg[i] = 16'($urandom & $urandom & $urandom) & 16'h00ff;
        if ((mpos[i] | mneg[i]) == 0) mpos[i][$urandom_range(7, 0)] = 1'b1;
      end
      load_all();
      ia = 16'($urandom & $urandom) & 16'h00ff;
      iv = 16'($urandom);
      model(ia, iv);
      run(ia, iv, 0);
      cmp("rnd");
    end
    fill(16'h0001);
    mpos[0] = 16'h0002;
    mneg[0] = 16'h0001;
    mpos[5] = 16'h0004;
    mneg[5] = 16'h0002;
    load_all();
    @(negedge clk);
    bus.init_assigned = 16'h0001;
    bus.init_value = 16'h0001;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_asg", bus.assigned, 0);
    chk("mid_cnt", bus.imp_count, 0);
    @(negedge clk);
    rst = 1'b0;
    o_dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) o_dones++;
    end
    chk("mid_nodone", o_dones, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
